wb_to_ahbl_bridge: RTL and testbench
====================================

WB_TO_AHBL_BRIDGE -- requirements
Module: wb_to_ahbl_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the number of HREADY-low cycles after which an outstanding transfer is abandoned with an error.
REQ-002 SHALL have the following ports, one per line as name, direction, width, meaning:
- HCLK  in  1  the single clock for all logic.
- HRESETn  in  1  reset, asynchronous, active-low.
- wb_cyc_i  in  1  Wishbone cycle.
- wb_stb_i  in  1  Wishbone strobe.
- wb_we_i  in  1  Wishbone write.
- wb_sel_i  in  4  byte lanes.
- wb_adr_i  in  32  byte address.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data.
- wb_ack_o  out  1  transfer done.
- wb_err_o  out  1  transfer failed.
- HADDR  out  32  AHB address.
- HTRANS  out  2  AHB transfer type.
- HWRITE  out  1  AHB write.
- HSIZE  out  3  AHB size.
- HWDATA  out  32  AHB write data.
- HREADY  in  1  combined slave ready (HREADYOUT of the selected slave).
- HRDATA  in  32  AHB read data.
- HRESP  in  1  AHB error response.
REQ-003 All outputs SHALL be driven directly from registers.

Function
REQ-004 SHALL implement the FSM IDLE, ADDR, DATA, which issues single NONSEQ transfers only (no bursts, no pipelining of back-to-back requests).
REQ-005 In IDLE, a request is wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o.
REQ-006 On a request with a legal wb_sel_i, the bridge SHALL register the following and move to ADDR:
- HADDR = {wb_adr_i[31:2], offset}.
- HWRITE = wb_we_i.
- HSIZE as given in REQ-007.
- HTRANS = 2'b10.
REQ-007 The wb_sel_i mapping SHALL be:
- 1111 -> HSIZE 010, offset 00.
- 0011 -> HSIZE 001, offset 00.
- 1100 -> HSIZE 001, offset 10.
- 0001/0010/0100/1000 -> HSIZE 000, offset 00/01/10/11.
REQ-008 Any other wb_sel_i value SHALL cause no AHB transfer; wb_err_o SHALL pulse high for one cycle on the next cycle and the FSM SHALL stay in IDLE.
REQ-009 In ADDR, at the first edge with HREADY=1, the bridge SHALL set HTRANS=2'b00, load HWDATA from wb_dat_i (latched at request), and move to DATA.
REQ-010 In DATA, at the first edge with HREADY=1:
- HRESP=0: wb_ack_o high for one cycle and, if the transfer was a read, wb_dat_o=HRDATA.
- HRESP=1: wb_err_o high for one cycle.
- In both cases the FSM SHALL return to IDLE.
REQ-011 With a zero-wait slave, latency SHALL be 3 cycles from the request-sampling edge to wb_ack_o high (HTRANS NONSEQ in cycle 1, data phase in cycle 2, ack in cycle 3).
REQ-012 Each HREADY-low cycle in ADDR or DATA SHALL add exactly one cycle of latency; HADDR, HWRITE, HSIZE, HTRANS and HWDATA SHALL be held stable while HREADY=0.
REQ-013 The first HRESP-high/HREADY-low cycle of a two-cycle AHB error response SHALL be treated as a wait state; the error is taken at the HREADY-high cycle.
REQ-014 A wait counter SHALL clear on entry to ADDR and increment on every HREADY-low cycle in ADDR/DATA. When it reaches TIMEOUT, the bridge SHALL pulse wb_err_o, force HTRANS=2'b00 and return to IDLE.
REQ-015 The wait counter SHALL saturate and SHALL NOT wrap.
REQ-016 If wb_cyc_i falls while in ADDR/DATA, the AHB transfer SHALL still complete per protocol; wb_ack_o/wb_err_o SHALL be suppressed for that transfer.
REQ-017 wb_ack_o and wb_err_o SHALL never be high in the same cycle and SHALL never be high for two consecutive cycles.
REQ-018 wb_dat_o SHALL hold its last value except when updated by a completed read.
REQ-019 HWDATA SHALL hold its value after the data phase until the next write data phase.

Reset
REQ-020 When HRESETn is low, all outputs SHALL immediately (asynchronously) take these values:
- HTRANS = 00.
- HADDR = 0, HWRITE = 0, HSIZE = 010, HWDATA = 0.
- wb_dat_o = 0, wb_ack_o = 0, wb_err_o = 0.
- FSM = IDLE, wait counter = 0.
REQ-021 Reset asserted mid-transfer SHALL abandon the transfer with no ack or err. After deassertion, the bridge SHALL wait for a fresh request.

Verification
REQ-022 Word write with zero-wait slave:
- Stimulus: adr 0x30000004, sel 1111, dat 0x00000001.
- Response: HADDR 0x30000004, HSIZE 010, HWRITE 1, NONSEQ for one cycle; HWDATA 0x00000001 in the next cycle; wb_ack_o 3 cycles after the request.
REQ-023 Read with 2 wait states:
- Stimulus: HREADY low for 2 data-phase cycles, HRDATA 0xDEADBEEF.
- Response: wb_ack_o at cycle 5 with wb_dat_o=0xDEADBEEF; HADDR stable throughout.
REQ-024 Byte write:
- Stimulus: sel 0100, adr 0x30000000.
- Response: HADDR 0x30000002, HSIZE 000.
REQ-025 Illegal sel:
- Stimulus: sel 0110.
- Response: HTRANS stays 00 and wb_err_o pulses one cycle.
REQ-026 Slave error and timeout:
- Stimulus A: two-cycle HRESP error.
- Response A: single wb_err_o pulse, no ack.
- Stimulus B: TIMEOUT=4 and HREADY held low.
- Response B: wb_err_o after 4 wait cycles and FSM back in IDLE.
REQ-027 Reset mid-DATA and wb_cyc_i abort:
- Stimulus A: HRESETn pulsed low during DATA.
- Response A: outputs immediately at reset values and no ack.
- Stimulus B: wb_cyc_i dropped during ADDR.
- Response B: AHB transfer completes and no wb_ack_o.

Source files
------------

// File: rtl/wb_to_ahbl_bridge.sv
`default_nettype none
// ============================================================================
// Module   : wb_to_ahbl_bridge
// Function : Wishbone classic slave to AHB-Lite master, single NONSEQ transfers.
// Revision : 1.0 - initial release
// ============================================================================
module wb_to_ahbl_bridge #(
  parameter int TIMEOUT = 255
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic [31:0] HRDATA,
  input  logic        HRESP
);

  localparam int c_CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_ADDR = 2'd1;
  localparam logic [1:0] c_DATA = 2'd2;

  localparam logic [1:0] c_HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;

  logic [1:0]         r_state, w_state_nxt;
  logic [31:0]        r_haddr, w_haddr_nxt;
  logic [1:0]         r_htrans, w_htrans_nxt;
  logic               r_hwrite, w_hwrite_nxt;
  logic [2:0]         r_hsize, w_hsize_nxt;
  logic [31:0]        r_hwdata, w_hwdata_nxt;
  logic [31:0]        r_dat, w_dat_nxt;
  logic               r_ack, w_ack_nxt;
  logic               r_err, w_err_nxt;
  logic [31:0]        r_wdat, w_wdat_nxt;
  logic               r_abort, w_abort_nxt;
  logic [c_CNT_W-1:0] r_wait_cnt, w_wait_cnt_nxt, w_wait_inc;

  logic       w_req, w_sel_ok, w_timeout, w_quiet;
  logic [2:0] w_size;
  logic [1:0] w_ofs;
  logic       w_unused;

  // Word-aligned address comes from the bus; the low bits come from the lanes.
  assign w_unused = ^wb_adr_i[1:0];

  assign w_req = wb_cyc_i & wb_stb_i & ~r_ack & ~r_err;

  always_comb begin
    w_sel_ok = 1'b1;
    w_size   = 3'b010;
    w_ofs    = 2'b00;
    case (wb_sel_i)
      4'b1111: begin w_size = 3'b010; w_ofs = 2'b00; end
      4'b0011: begin w_size = 3'b001; w_ofs = 2'b00; end
      4'b1100: begin w_size = 3'b001; w_ofs = 2'b10; end
      4'b0001: begin w_size = 3'b000; w_ofs = 2'b00; end
      4'b0010: begin w_size = 3'b000; w_ofs = 2'b01; end
      4'b0100: begin w_size = 3'b000; w_ofs = 2'b10; end
      4'b1000: begin w_size = 3'b000; w_ofs = 2'b11; end
      default: w_sel_ok = 1'b0;
    endcase
  end

  assign w_wait_inc = (r_wait_cnt == c_TIMEOUT) ? r_wait_cnt : r_wait_cnt + 1'b1;
  assign w_timeout  = ~HREADY & (w_wait_inc == c_TIMEOUT);
  // A master that has walked away gets neither ack nor err for this transfer.
  assign w_quiet    = r_abort | ~wb_cyc_i;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) r_state <= c_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (w_req && w_sel_ok) w_state_nxt = c_ADDR;
      c_ADDR:  if (HREADY) w_state_nxt = c_DATA;
               else if (w_timeout) w_state_nxt = c_IDLE;
      c_DATA:  if (HREADY || w_timeout) w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    w_haddr_nxt    = r_haddr;
    w_htrans_nxt   = r_htrans;
    w_hwrite_nxt   = r_hwrite;
    w_hsize_nxt    = r_hsize;
    w_hwdata_nxt   = r_hwdata;
    w_dat_nxt      = r_dat;
    w_ack_nxt      = 1'b0;
    w_err_nxt      = 1'b0;
    w_wdat_nxt     = r_wdat;
    w_abort_nxt    = r_abort;
    w_wait_cnt_nxt = r_wait_cnt;
    case (r_state)
      c_IDLE: begin
        if (w_req) begin
          if (w_sel_ok) begin
            w_haddr_nxt    = {wb_adr_i[31:2], w_ofs};
            w_hwrite_nxt   = wb_we_i;
            w_hsize_nxt    = w_size;
            w_htrans_nxt   = c_HTRANS_NONSEQ;
            w_wdat_nxt     = wb_dat_i;
            w_abort_nxt    = 1'b0;
            w_wait_cnt_nxt = '0;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      c_ADDR: begin
        if (!wb_cyc_i) w_abort_nxt = 1'b1;
        if (HREADY) begin
          w_htrans_nxt = c_HTRANS_IDLE;
          if (r_hwrite) w_hwdata_nxt = r_wdat;
        end else begin
          w_wait_cnt_nxt = w_wait_inc;
          if (w_timeout) begin
            w_htrans_nxt = c_HTRANS_IDLE;
            w_err_nxt    = ~w_quiet;
          end
        end
      end
      c_DATA: begin
        if (!wb_cyc_i) w_abort_nxt = 1'b1;
        // HRESP with HREADY low is the first half of an error: just a wait.
        if (HREADY) begin
          if (HRESP) begin
            w_err_nxt = ~w_quiet;
          end else begin
            w_ack_nxt = ~w_quiet;
            if (!r_hwrite && !w_quiet) w_dat_nxt = HRDATA;
          end
        end else begin
          w_wait_cnt_nxt = w_wait_inc;
          if (w_timeout) w_err_nxt = ~w_quiet;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_haddr    <= '0;
      r_htrans   <= c_HTRANS_IDLE;
      r_hwrite   <= 1'b0;
      r_hsize    <= 3'b010;
      r_hwdata   <= '0;
      r_dat      <= '0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_wdat     <= '0;
      r_abort    <= 1'b0;
      r_wait_cnt <= '0;
    end else begin
      r_haddr    <= w_haddr_nxt;
      r_htrans   <= w_htrans_nxt;
      r_hwrite   <= w_hwrite_nxt;
      r_hsize    <= w_hsize_nxt;
      r_hwdata   <= w_hwdata_nxt;
      r_dat      <= w_dat_nxt;
      r_ack      <= w_ack_nxt;
      r_err      <= w_err_nxt;
      r_wdat     <= w_wdat_nxt;
      r_abort    <= w_abort_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  assign HADDR    = r_haddr;
  assign HTRANS   = r_htrans;
  assign HWRITE   = r_hwrite;
  assign HSIZE    = r_hsize;
  assign HWDATA   = r_hwdata;
  assign wb_dat_o = r_dat;
  assign wb_ack_o = r_ack;
  assign wb_err_o = r_err;

endmodule
`default_nettype wire

// File: tb/tb_wb_to_ahbl_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_to_ahbl_bridge
// Function : Directed vectors for wb_to_ahbl_bridge with hand-computed results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_to_ahbl_bridge;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic        wb_ack_o, wb_err_o;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HREADY, HRESP;
  logic [2:0]  HSIZE;

  int n_vec = 0;
  int n_err = 0;

  always #5 HCLK = ~HCLK;

  wb_to_ahbl_bridge #(.TIMEOUT(4)) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .wb_cyc_i (wb_cyc_i),
    .wb_stb_i (wb_stb_i),
    .wb_we_i  (wb_we_i),
    .wb_sel_i (wb_sel_i),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack_o),
    .wb_err_o (wb_err_o),
    .HADDR    (HADDR),
    .HTRANS   (HTRANS),
    .HWRITE   (HWRITE),
    .HSIZE    (HSIZE),
    .HWDATA   (HWDATA),
    .HREADY   (HREADY),
    .HRDATA   (HRDATA),
    .HRESP    (HRESP)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_htrans"}, HTRANS, 32'h0);
    chk({tag, "_haddr"},  HADDR,  32'h0);
    chk({tag, "_hwrite"}, HWRITE, 32'h0);
    chk({tag, "_hsize"},  HSIZE,  32'h2);
    chk({tag, "_hwdata"}, HWDATA, 32'h0);
    chk({tag, "_dat"},    wb_dat_o, 32'h0);
    chk({tag, "_ack"},    wb_ack_o, 32'h0);
    chk({tag, "_err"},    wb_err_o, 32'h0);
  endtask

  // Full zero-wait write: NONSEQ, then data phase, then ack, then ack drops.
  task automatic do_write(input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat,
                          input logic [31:0] exp_addr, input logic [2:0] exp_size);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_sel_i = sel; wb_adr_i = adr; wb_dat_i = dat;
    tick();
    chk("wr_htrans_nonseq", HTRANS, 32'h2);
    chk("wr_haddr", HADDR, exp_addr);
    chk("wr_hsize", HSIZE, {29'h0, exp_size});
    chk("wr_hwrite", HWRITE, 32'h1);
    tick();
    chk("wr_htrans_idle", HTRANS, 32'h0);
    chk("wr_hwdata", HWDATA, dat);
    chk("wr_no_early_ack", wb_ack_o, 32'h0);
    tick();
    chk("wr_ack", wb_ack_o, 32'h1);
    chk("wr_no_err", wb_err_o, 32'h0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    tick();
    chk("wr_ack_single", wb_ack_o, 32'h0);
  endtask

  initial begin
    HRESETn = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_sel_i = 4'h0; wb_adr_i = 32'h0; wb_dat_i = 32'h0;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
    tick(); tick();
    chk_reset_vals("rst");
    HRESETn = 1'b1;
    tick();

    // Word write, zero-wait slave
    do_write(32'h3000_0004, 4'b1111, 32'h0000_0001, 32'h3000_0004, 3'b010);

    // Byte and halfword lane mapping
    do_write(32'h3000_0000, 4'b0100, 32'h00AB_0000, 32'h3000_0002, 3'b000);
    do_write(32'h3000_0020, 4'b1100, 32'h1234_0000, 32'h3000_0022, 3'b001);
    do_write(32'h3000_0040, 4'b1000, 32'h5600_0000, 32'h3000_0043, 3'b000);

    // Read with two data-phase wait states
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
    wb_sel_i = 4'b1111; wb_adr_i = 32'h3000_0010;
    tick();
    chk("rd_htrans_nonseq", HTRANS, 32'h2);
    chk("rd_haddr_c1", HADDR, 32'h3000_0010);
    chk("rd_hwrite", HWRITE, 32'h0);
    tick();
    chk("rd_htrans_idle", HTRANS, 32'h0);
    HREADY = 1'b0;
    tick();
    chk("rd_wait1_ack", wb_ack_o, 32'h0);
    chk("rd_haddr_c3", HADDR, 32'h3000_0010);
    tick();
    chk("rd_wait2_ack", wb_ack_o, 32'h0);
    chk("rd_haddr_c4", HADDR, 32'h3000_0010);
    HREADY = 1'b1; HRDATA = 32'hDEAD_BEEF;
    tick();
    chk("rd_ack_c5", wb_ack_o, 32'h1);
    chk("rd_data", wb_dat_o, 32'hDEAD_BEEF);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; HRDATA = 32'h0;
    tick();
    chk("rd_ack_single", wb_ack_o, 32'h0);
    chk("rd_data_hold", wb_dat_o, 32'hDEAD_BEEF);

    // Illegal byte-lane pattern: no transfer, one err pulse even with stb held
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_sel_i = 4'b0110;
    tick();
    chk("ill_htrans", HTRANS, 32'h0);
    chk("ill_err", wb_err_o, 32'h1);
    chk("ill_no_ack", wb_ack_o, 32'h0);
    tick();
    chk("ill_err_single", wb_err_o, 32'h0);
    chk("ill_htrans_still", HTRANS, 32'h0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    tick();

    // Two-cycle slave error response
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_sel_i = 4'b1111; wb_adr_i = 32'h3000_0100; wb_dat_i = 32'hCAFE_0001;
    tick();
    tick();
    HREADY = 1'b0; HRESP = 1'b1;
    tick();
    chk("serr_first_err", wb_err_o, 32'h0);
    chk("serr_first_ack", wb_ack_o, 32'h0);
    HREADY = 1'b1;
    tick();
    chk("serr_err", wb_err_o, 32'h1);
    chk("serr_no_ack", wb_ack_o, 32'h0);
    HRESP = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    tick();
    chk("serr_err_single", wb_err_o, 32'h0);

    // Timeout with TIMEOUT=4 and HREADY stuck low
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h3000_0200;
    tick();
    HREADY = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("to_wait_err", wb_err_o, 32'h0);
      chk("to_htrans_held", HTRANS, 32'h2);
    end
    tick();
    chk("to_err", wb_err_o, 32'h1);
    chk("to_htrans_idle", HTRANS, 32'h0);
    HREADY = 1'b1; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    tick();
    chk("to_err_single", wb_err_o, 32'h0);
    do_write(32'h3000_0300, 4'b0011, 32'h0000_BEEF, 32'h3000_0300, 3'b001);

    // Reset asserted during the data phase
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_sel_i = 4'b1111; wb_adr_i = 32'h3000_0400; wb_dat_i = 32'h7777_7777;
    tick();
    tick();
    HRESETn = 1'b0;
    #1;
    chk_reset_vals("midrst");
    tick();
    HRESETn = 1'b1; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    tick();
    chk("midrst_no_ack", wb_ack_o, 32'h0);
    chk("midrst_htrans", HTRANS, 32'h0);

    // wb_cyc_i dropped during the address phase
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
    wb_sel_i = 4'b1111; wb_adr_i = 32'h3000_0500;
    tick();
    chk("cyc_nonseq", HTRANS, 32'h2);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; HREADY = 1'b0;
    tick();
    chk("cyc_addr_held", HTRANS, 32'h2);
    HREADY = 1'b1; HRDATA = 32'h1234_5678;
    tick();
    chk("cyc_data_phase", HTRANS, 32'h0);
    tick();
    chk("cyc_no_ack", wb_ack_o, 32'h0);
    chk("cyc_no_err", wb_err_o, 32'h0);
    HRDATA = 32'h0;
    tick();
    do_write(32'h3000_0600, 4'b0001, 32'h0000_00A5, 32'h3000_0600, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
